// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: recovers start/DATA_BITS/stop frames from rx and
// hands each word out through valid/ready, with framing-error and overrun pulses.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [TW-1:0]        tick_cnt_r, tick_cnt_nxt_s;
  logic [BW-1:0]        bit_cnt_r, bit_cnt_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic [1:0]           sync_r;
  logic                 rx_s;
  logic                 mid_stop_s;
  logic                 deliver_s;
  logic                 drop_s;
  logic                 bad_stop_s;
  logic                 handshake_s;

  assign rx_s        = sync_r[1];
  assign handshake_s = rx_valid && rx_ready;

  // Two-flop synchronizer for the asynchronous rx line (idles high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // FSM state, bit timing counters and data shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
    end
  end

  // Next-state logic; everything holds on cycles without a sample tick.
  always_comb begin
    state_nxt_s    = state_r;
    tick_cnt_nxt_s = tick_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    if (sample_tick) begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_nxt_s    = START;
            tick_cnt_nxt_s = TICK_ZERO;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          // A start bit that is no longer low at its midpoint was a glitch.
          if (tick_cnt_r == HALF_LAST) begin
            tick_cnt_nxt_s = TICK_ZERO;
            bit_cnt_nxt_s  = BIT_ZERO;
            state_nxt_s    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_cnt_nxt_s = TICK_ZERO;
            shift_nxt_s    = {rx_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_nxt_s  = bit_cnt_r + BIT_ONE;
            state_nxt_s    = (bit_cnt_r == BIT_LAST) ? STOP : DATA;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_cnt_nxt_s = TICK_ZERO;
            state_nxt_s    = rx_s ? IDLE : WAIT_IDLE;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end
        WAIT_IDLE: begin
          state_nxt_s = rx_s ? IDLE : WAIT_IDLE;
        end
        default: begin
          state_nxt_s    = IDLE;
          tick_cnt_nxt_s = TICK_ZERO;
          bit_cnt_nxt_s  = BIT_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Stop-bit outcome: deliver, drop as overrun, or flag a framing error.
  always_comb begin
    mid_stop_s = sample_tick && (state_r == STOP) && (tick_cnt_r == FULL_LAST);
    deliver_s  = 1'b0;
    drop_s     = 1'b0;
    bad_stop_s = 1'b0;
    if (mid_stop_s) begin
      if (!rx_s) begin
        bad_stop_s = 1'b1;
      end else if (rx_valid && !rx_ready) begin
        drop_s = 1'b1;
      end else begin
        deliver_s = 1'b1;
      end
    end else begin
      deliver_s = 1'b0;
    end
  end

  // Registered handshake outputs and single-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= {DATA_BITS{1'b0}};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop_s;
      overrun   <= drop_s;
      if (deliver_s) begin
        rx_data  <= shift_r;
        rx_valid <= 1'b1;
      end else if (handshake_s) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule
